instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The module SHALL have parameter BITSIZE, default 32: the instruction width.
REQ-002 The module SHALL have parameter REGSIZE, default 64: the address/PC width.
REQ-003 The module SHALL have parameter MEM_DEPTH, default 64: the instruction memory word count and PC wrap modulus.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: a synchronous, active-high reset.
REQ-006 Port imem_addr SHALL be an output, REGSIZE bits: the word index driven to the instruction memory Address input.
REQ-007 Port imem_data SHALL be an input, BITSIZE bits: the instruction memory ReadData1, valid combinationally in the same cycle.
REQ-008 Port redirect_valid SHALL be an input, 1 bit: the decode/execute branch redirect strobe.
REQ-009 Port redirect_target SHALL be an input, REGSIZE bits: the redirect word index.
REQ-010 Port out_valid SHALL be an output, 1 bit: an instruction is available to decode.
REQ-011 Port out_ready SHALL be an input, 1 bit: decode accepts the instruction.
REQ-012 Port out_instr SHALL be an output, BITSIZE bits: the head instruction.
REQ-013 Port out_pc SHALL be an output, REGSIZE bits: the word index of out_instr.

Function
REQ-014 The module SHALL hold pc, a 2-entry FIFO of {pc, instr}, and an FSM with states IDLE, FETCH and HOLD.
REQ-015 imem_addr SHALL equal pc at all times.
REQ-016 IDLE SHALL perform no capture and SHALL transition to FETCH unconditionally on the next cycle.
REQ-017 FETCH SHALL push {pc, imem_data} into the FIFO and advance pc to next_pc.
REQ-018 FETCH SHALL transition to HOLD when the push leaves the FIFO count at 2.
REQ-019 HOLD SHALL not push and SHALL hold pc.
REQ-020 HOLD SHALL transition to FETCH in the cycle after a pop.
REQ-021 next_pc SHALL be (pc+1) mod MEM_DEPTH; pc MEM_DEPTH-1 SHALL wrap to 0.
REQ-022 out_valid SHALL be 1 exactly when the FIFO count is nonzero; out_instr/out_pc SHALL show the head entry.
REQ-023 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-024 A push and a pop at count 1 SHALL leave the count at 1 with the new entry at the head.
REQ-025 While out_valid=0, out_instr and out_pc SHALL be 0.
REQ-026 When redirect_valid=1 in FETCH or HOLD: the FIFO SHALL be flushed, pc SHALL load redirect_target mod MEM_DEPTH, there SHALL be no push, and the state SHALL become FETCH.
REQ-027 A pop handshake in the same cycle as a redirect SHALL count as consumed.
REQ-028 redirect_valid in IDLE SHALL load pc only.
REQ-029 Instruction latency SHALL be 1 cycle from pc update to out_valid.

Reset
REQ-030 With reset=1 at a clock edge, pc SHALL be 0, the FIFO count 0, the state IDLE, out_valid 0, out_instr 0, out_pc 0 and imem_addr 0.
REQ-031 Reset SHALL override redirect and handshake in the same cycle.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries.

Configuration
REQ-033 With macro IFU_BRANCH_PREDICT_EN defined, a FETCH push whose imem_data[31:26]==6'b000101 (B) SHALL set next_pc = (pc + sign-extended imem_data[25:0]) mod MEM_DEPTH.
REQ-034 Without IFU_BRANCH_PREDICT_EN, next_pc SHALL always be (pc+1) mod MEM_DEPTH.
REQ-035 In both builds, a B instruction SHALL still be delivered to decode.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef (IDLE/FETCH/HOLD), the B opcode constant 6'b000101, and the BITSIZE/REGSIZE/MEM_DEPTH defaults.
REQ-037 The 2-entry FIFO SHALL be a sub-module named ifu_fifo2 with push/pop/flush, count and head outputs.

Verification
REQ-038 Reset release, out_ready=1, mem[0..2]={A,B,C} -> out_valid=0 in the first cycle; then out_pc 0,1,2 with A,B,C on consecutive cycles.
REQ-039 out_ready=0 from reset -> FIFO fills with pc 0,1; state HOLD; imem_addr holds 2; one pop -> fetch of pc 2 resumes the next cycle.
REQ-040 FIFO full (pc 0,1), redirect_valid=1, target 10 -> FIFO empty the next cycle; following out_pc=10; entries 0/1 never seen unless popped in the redirect cycle.
REQ-041 redirect target 63, out_ready=1 -> out_pc sequence 63,0,1.
REQ-042 mem[11]=B with imm26=3: macro on -> out_pc 11 then 14; macro off -> 11 then 12.
REQ-043 reset asserted with FIFO count 2 -> next cycle out_valid=0, imem_addr=0, state IDLE.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// the B opcode, parameter defaults and an opcode helper.
package instruction_fetch_unit_pkg;

    localparam int IFU_BITSIZE   = 32;
    localparam int IFU_REGSIZE   = 64;
    localparam int IFU_MEM_DEPTH = 64;

    localparam logic [5:0] OP_B = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } ifu_state_e;

    function automatic logic is_branch(input logic [31:0] instr);
        return instr[31:26] == OP_B;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo2.sv
// ifu_fifo2: two-entry {pc, instr} queue between fetch and decode.
// Ports: clk, reset (sync, active high), i_push/i_pc/i_instr,
//        i_pop, i_flush, o_count, o_head_pc/o_head_instr (0 when empty).
module ifu_fifo2
    import instruction_fetch_unit_pkg::*;
#(
    parameter int BITSIZE = IFU_BITSIZE,
    parameter int REGSIZE = IFU_REGSIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [REGSIZE-1:0] i_pc,
    input  logic [BITSIZE-1:0] i_instr,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [1:0]         o_count,
    output logic [REGSIZE-1:0] o_head_pc,
    output logic [BITSIZE-1:0] o_head_instr
);

    logic [1:0]         r_count;
    logic [REGSIZE-1:0] r_pc0, r_pc1;
    logic [BITSIZE-1:0] r_in0, r_in1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_pc0   <= '0;
            r_pc1   <= '0;
            r_in0   <= '0;
            r_in1   <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0   <= i_pc;
                        r_in0   <= i_instr;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_pc1   <= i_pc;
                        r_in1   <= i_instr;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_pc0   <= r_pc1;
                        r_in0   <= r_in1;
                        r_count <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    // Head leaves while the new entry joins: count unchanged.
                    if (r_count == 2'd2) begin
                        r_pc0 <= r_pc1;
                        r_in0 <= r_in1;
                        r_pc1 <= i_pc;
                        r_in1 <= i_instr;
                    end else begin
                        r_pc0   <= i_pc;
                        r_in0   <= i_instr;
                        r_count <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_pc    = (r_count != 2'd0) ? r_pc0 : '0;
    assign o_head_instr = (r_count != 2'd0) ? r_in0 : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks pc through instruction memory, buffers
// {pc, instr} in a 2-entry queue and hands them to decode by valid/ready.
// Ports: clk, reset (sync, active high), imem_addr/imem_data (memory),
//        redirect_valid/redirect_target (branch redirect),
//        out_valid/out_ready/out_instr/out_pc (decode handshake).
// Macro IFU_BRANCH_PREDICT_EN: follow B instructions at fetch time.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int BITSIZE   = IFU_BITSIZE,
    parameter int REGSIZE   = IFU_REGSIZE,
    parameter int MEM_DEPTH = IFU_MEM_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    output logic [REGSIZE-1:0] imem_addr,
    input  logic [BITSIZE-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [REGSIZE-1:0] redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] out_instr,
    output logic [REGSIZE-1:0] out_pc
);

    localparam logic [REGSIZE-1:0] DEPTH = REGSIZE'(MEM_DEPTH);
    localparam logic [REGSIZE-1:0] LAST  = REGSIZE'(MEM_DEPTH - 1);

    ifu_state_e         r_state, w_state_nxt;
    logic [REGSIZE-1:0] r_pc, w_pc_nxt;
    logic [REGSIZE-1:0] w_seq_pc, w_next_pc, w_redir_pc;
    logic [1:0]         w_cnt, w_cnt_after;
    logic               w_push, w_pop, w_flush;

    assign w_seq_pc   = (r_pc == LAST) ? '0 : r_pc + 1'b1;
    assign w_redir_pc = redirect_target % DEPTH;

`ifdef IFU_BRANCH_PREDICT_EN
    logic signed [REGSIZE:0] w_br_sum, w_br_mod;

    // Signed modulo so backward offsets wrap into [0, MEM_DEPTH).
    always_comb begin
        w_br_sum = $signed({1'b0, r_pc})
                 + $signed({{(REGSIZE-25){imem_data[25]}},
                            imem_data[25:0]});
        w_br_mod = w_br_sum % $signed({1'b0, DEPTH});
        if (w_br_mod < 0) begin
            w_br_mod = w_br_mod + $signed({1'b0, DEPTH});
        end
    end

    assign w_next_pc = is_branch(imem_data[31:0])
                     ? w_br_mod[REGSIZE-1:0] : w_seq_pc;
`else
    assign w_next_pc = w_seq_pc;
`endif

    assign w_pop       = out_valid & out_ready;
    assign w_cnt_after = w_cnt + 2'd1 - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (redirect_valid) w_pc_nxt = w_redir_pc;
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_redir_pc;
                end else begin
                    w_push   = 1'b1;
                    w_pc_nxt = w_next_pc;
                    if (w_cnt_after == 2'd2) w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = FETCH;
                end else if (w_pop) begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    ifu_fifo2 #(
        .BITSIZE(BITSIZE),
        .REGSIZE(REGSIZE)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pc        (r_pc),
        .i_instr     (imem_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_count     (w_cnt),
        .o_head_pc   (out_pc),
        .o_head_instr(out_instr)
    );

    assign imem_addr = r_pc;
    assign out_valid = (w_cnt != 2'd0);

endmodule
